// File: rtl/dz_modem_scan.sv
// dz_modem_scan
// Modem-status change scanner for the DZ11 line block. Walks the eight lines
// round-robin at a programmable rate and debounces each line's CO/RI pair.
// It keeps a debounced status image and hands per-line change events to the
// interrupt/CSR logic, one at a time, over a req/ack handshake.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   msrIN    synchronized MSR, [15:8]=CO line 7..0, [7:0]=RI line 7..0
//   scanEN   1 = scanning runs, 0 = prescaler/pointer/debounce frozen
//   evtACK   consumer accepts the presented event
//   ovrCLR   clears the sticky overrun flag
//   evtREQ   event valid
//   evtLINE  line number of the presented event
//   evtCO    debounced CO of evtLINE, captured when the event was offered
//   evtRI    debounced RI of evtLINE, captured when the event was offered
//   stsMSR   debounced status image, same layout as msrIN
//   overrun  sticky: a change was accepted on a line whose event was pending

module dz_modem_scan #(
   parameter int DEBOUNCE = 4,
   parameter int SCAN_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] msrIN,
   input  logic        scanEN,
   input  logic        evtACK,
   input  logic        ovrCLR,
   output logic        evtREQ,
   output logic [2:0]  evtLINE,
   output logic        evtCO,
   output logic        evtRI,
   output logic [15:0] stsMSR,
   output logic        overrun
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);

   typedef enum logic {
      IDLE,
      OFFER
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [2:0]    ptr;
   logic [2:0]    rrPtr;
   logic [CW-1:0] cnt [8];
   logic [7:0]    stableCo;
   logic [7:0]    stableRi;
   logic [7:0]    pending;

   logic          tick;
   logic [7:0]    coIn;
   logic [7:0]    riIn;
   logic          sampleCo;
   logic          sampleRi;
   logic          differs;
   logic          accept;
   logic [7:0]    acceptMask;
   logic [7:0]    ackMask;
   logic          selFound;
   logic [2:0]    selLine;
   logic [2:0]    idx;

   // The scan tick fires on the last prescaler count. Only the line under
   // the pointer is compared against its stable value, and acceptance
   // happens when that line has already differed DEBOUNCE-1 times in a row.
   always_comb begin
      tick       = scanEN && (presc == PRESC_LAST);
      coIn       = msrIN[15:8];
      riIn       = msrIN[7:0];
      sampleCo   = coIn[ptr];
      sampleRi   = riIn[ptr];
      differs    = (sampleCo != stableCo[ptr]) || (sampleRi != stableRi[ptr]);
      accept     = tick && differs && (cnt[ptr] == CNT_LAST);
      acceptMask = accept ? (8'b1 << ptr) : 8'b0;
      ackMask    = ((state == OFFER) && evtACK) ? (8'b1 << evtLINE) : 8'b0;
   end

   // Round-robin pick: the first pending line at or above rrPtr, wrapping
   // past line 7 back to line 0, so a busy low line cannot starve others.
   always_comb begin
      selFound = 1'b0;
      selLine  = rrPtr;
      idx      = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = rrPtr + 3'(i);
         if (!selFound && pending[idx]) begin
            selFound = 1'b1;
            selLine  = idx;
         end
      end
   end

   // Prescaler, scan pointer and per-line debounce counters. Everything
   // here holds its value while scanEN is low, so a paused scan resumes
   // exactly where it left off. Any sample matching the stable value
   // restarts that line's count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc    <= '0;
         ptr      <= 3'd0;
         stableCo <= 8'd0;
         stableRi <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
      end else if (scanEN) begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            ptr <= ptr + 3'd1;
            if (!differs) begin
               cnt[ptr] <= '0;
            end else if (cnt[ptr] != CNT_LAST) begin
               cnt[ptr] <= cnt[ptr] + 1'b1;
            end else begin
               stableCo[ptr] <= sampleCo;
               stableRi[ptr] <= sampleRi;
               cnt[ptr]      <= '0;
            end
         end
      end
   end

   // Status image trails the stable registers by one clock. Overrun is
   // sticky and a fresh overrun beats a clear arriving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stsMSR  <= 16'd0;
         overrun <= 1'b0;
      end else begin
         stsMSR <= {stableCo, stableRi};
         if (accept && pending[ptr]) begin
            overrun <= 1'b1;
         end else if (ovrCLR) begin
            overrun <= 1'b0;
         end
      end
   end

   // Event delivery. The offered CO/RI are snapshots taken when the event
   // is loaded, so later line activity cannot disturb a held offer. A new
   // acceptance on the line being acked keeps its pending bit set, so the
   // fresh values are offered again later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pending <= 8'd0;
         rrPtr   <= 3'd0;
         evtREQ  <= 1'b0;
         evtLINE <= 3'd0;
         evtCO   <= 1'b0;
         evtRI   <= 1'b0;
      end else begin
         pending <= (pending & ~ackMask) | acceptMask;
         case (state)
            IDLE: begin
               if (selFound) begin
                  evtLINE <= selLine;
                  evtCO   <= stableCo[selLine];
                  evtRI   <= stableRi[selLine];
                  evtREQ  <= 1'b1;
                  state   <= OFFER;
               end
            end
            OFFER: begin
               if (evtACK) begin
                  rrPtr  <= evtLINE + 3'd1;
                  evtREQ <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               evtREQ <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dz_modem_scan.sv
// tb_dz_modem_scan
// Directed testbench for dz_modem_scan with DEBOUNCE=4 and SCAN_DIV=4, so
// each line is sampled once every 32 clocks and a change needs four
// consecutive differing samples before it is accepted.
// Ports driven: clk, rst, msrIN, scanEN, evtACK, ovrCLR; all outputs observed.

module tb_dz_modem_scan;

   logic        clk;
   logic        rst;
   logic        clkEn;
   logic [15:0] msrIN;
   logic        scanEN;
   logic        evtACK;
   logic        ovrCLR;
   logic        evtREQ;
   logic [2:0]  evtLINE;
   logic        evtCO;
   logic        evtRI;
   logic [15:0] stsMSR;
   logic        overrun;

   int checkCount;
   int errorCount;
   bit sawReq;

   dz_modem_scan #(
      .DEBOUNCE(4),
      .SCAN_DIV(4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .msrIN  (msrIN),
      .scanEN (scanEN),
      .evtACK (evtACK),
      .ovrCLR (ovrCLR),
      .evtREQ (evtREQ),
      .evtLINE(evtLINE),
      .evtCO  (evtCO),
      .evtRI  (evtRI),
      .stsMSR (stsMSR),
      .overrun(overrun)
   );

   // The clock stays low until clkEn is raised, so reset can be checked
   // with the clock idle.
   always begin
      #5;
      if (clkEn) clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] msr, input logic en);
      msrIN  = msr;
      scanEN = en;
   endtask

   // Advance n clocks, leaving time 1 unit past the active edge.
   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance n clocks, remembering whether evtREQ was ever seen high.
   task automatic watchCycles(input int n);
      sawReq = 1'b0;
      repeat (n) begin
         stepCycles(1);
         if (evtREQ) sawReq = 1'b1;
      end
   endtask

   // Bounded wait for an offered event; a timeout shows up as evtREQ=0
   // in the caller's following check.
   task automatic waitForReq(input int maxCycles);
      int n;
      n = 0;
      while (!evtREQ && n < maxCycles) begin
         stepCycles(1);
         n++;
      end
   endtask

   task automatic ackEvent(input string tag);
      evtACK = 1'b1;
      stepCycles(1);
      evtACK = 1'b0;
      checkOutput(tag, {15'd0, evtREQ}, 16'd0);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      sawReq     = 1'b0;
      clk        = 1'b0;
      clkEn      = 1'b0;
      rst        = 1'b0;
      evtACK     = 1'b0;
      ovrCLR     = 1'b0;
      applyStimulus(16'h0000, 1'b1);

      // Reset with the clock idle, then run quietly.
      #2 rst = 1'b1;
      #2;
      checkOutput("rst_evtREQ",  {15'd0, evtREQ}, 16'd0);
      checkOutput("rst_evtLINE", {13'd0, evtLINE}, 16'd0);
      checkOutput("rst_evtCO",   {15'd0, evtCO}, 16'd0);
      checkOutput("rst_evtRI",   {15'd0, evtRI}, 16'd0);
      checkOutput("rst_stsMSR",  stsMSR, 16'h0000);
      checkOutput("rst_overrun", {15'd0, overrun}, 16'd0);
      #2 rst = 1'b0;
      clkEn = 1'b1;
      watchCycles(500);
      checkOutput("idle_noreq", {15'd0, sawReq}, 16'd0);

      // Steady CO on line 3 produces one event after debounce.
      applyStimulus(16'h0800, 1'b1);
      stepCycles(40);
      checkOutput("co3_early_sts", stsMSR, 16'h0000);
      waitForReq(200);
      checkOutput("co3_req",  {15'd0, evtREQ}, 16'd1);
      checkOutput("co3_sts",  stsMSR, 16'h0800);
      checkOutput("co3_line", {13'd0, evtLINE}, 16'd3);
      checkOutput("co3_co",   {15'd0, evtCO}, 16'd1);
      checkOutput("co3_ri",   {15'd0, evtRI}, 16'd0);
      stepCycles(10);
      checkOutput("co3_hold_req",  {15'd0, evtREQ}, 16'd1);
      checkOutput("co3_hold_line", {13'd0, evtLINE}, 16'd3);
      ackEvent("co3_ack_drop");
      watchCycles(100);
      checkOutput("co3_no_repeat", {15'd0, sawReq}, 16'd0);

      // A glitch on RI line 5 lasting exactly three samples is rejected.
      applyStimulus(16'h0820, 1'b1);
      stepCycles(96);
      applyStimulus(16'h0800, 1'b1);
      watchCycles(100);
      checkOutput("glitch_noreq",   {15'd0, sawReq}, 16'd0);
      checkOutput("glitch_sts",     stsMSR, 16'h0800);
      checkOutput("glitch_overrun", {15'd0, overrun}, 16'd0);

      // Round-robin: while line 2 is held unacked, lines 1 and 6 become
      // pending; after acking line 2 the search starts at line 3.
      applyStimulus(16'h0C00, 1'b1);
      waitForReq(200);
      checkOutput("rr_l2_req",  {15'd0, evtREQ}, 16'd1);
      checkOutput("rr_l2_line", {13'd0, evtLINE}, 16'd2);
      applyStimulus(16'h4E00, 1'b1);
      stepCycles(200);
      checkOutput("rr_l2_held", {13'd0, evtLINE}, 16'd2);
      checkOutput("rr_l2_co",   {15'd0, evtCO}, 16'd1);
      ackEvent("rr_l2_ack_drop");
      waitForReq(5);
      checkOutput("rr_first_req",  {15'd0, evtREQ}, 16'd1);
      checkOutput("rr_first_line", {13'd0, evtLINE}, 16'd6);
      checkOutput("rr_sts",        stsMSR, 16'h4E00);
      ackEvent("rr_l6_ack_drop");
      waitForReq(5);
      checkOutput("rr_second_req",  {15'd0, evtREQ}, 16'd1);
      checkOutput("rr_second_line", {13'd0, evtLINE}, 16'd1);
      checkOutput("rr_overrun",     {15'd0, overrun}, 16'd0);

      // Reset in the middle of an offer drops evtREQ at once.
      applyStimulus(16'h0000, 1'b1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_req", {15'd0, evtREQ}, 16'd0);
      checkOutput("midrst_sts", stsMSR, 16'h0000);
      stepCycles(1);
      rst = 1'b0;

      // Overrun: line 7 blocks delivery while CO line 2 toggles on then off.
      applyStimulus(16'h0080, 1'b1);
      waitForReq(200);
      checkOutput("ovr_l7_line", {13'd0, evtLINE}, 16'd7);
      checkOutput("ovr_l7_ri",   {15'd0, evtRI}, 16'd1);
      checkOutput("ovr_l7_co",   {15'd0, evtCO}, 16'd0);
      applyStimulus(16'h0480, 1'b1);
      stepCycles(200);
      checkOutput("ovr_first_change", {15'd0, overrun}, 16'd0);
      applyStimulus(16'h0080, 1'b1);
      stepCycles(200);
      checkOutput("ovr_set",     {15'd0, overrun}, 16'd1);
      checkOutput("ovr_l7_held", {13'd0, evtLINE}, 16'd7);
      checkOutput("ovr_sts",     stsMSR, 16'h0080);
      ackEvent("ovr_l7_ack_drop");
      waitForReq(5);
      checkOutput("ovr_l2_req",  {15'd0, evtREQ}, 16'd1);
      checkOutput("ovr_l2_line", {13'd0, evtLINE}, 16'd2);
      checkOutput("ovr_l2_co",   {15'd0, evtCO}, 16'd0);
      checkOutput("ovr_sticky",  {15'd0, overrun}, 16'd1);
      ovrCLR = 1'b1;
      stepCycles(1);
      ovrCLR = 1'b0;
      checkOutput("ovr_cleared", {15'd0, overrun}, 16'd0);
      ackEvent("ovr_l2_ack_drop");
      watchCycles(50);
      checkOutput("ovr_single_event", {15'd0, sawReq}, 16'd0);

      // scanEN low freezes scanning but still lets the offer complete.
      applyStimulus(16'h0081, 1'b1);
      waitForReq(200);
      checkOutput("frz_l0_line", {13'd0, evtLINE}, 16'd0);
      checkOutput("frz_l0_ri",   {15'd0, evtRI}, 16'd1);
      applyStimulus(16'h1081, 1'b0);
      stepCycles(5);
      checkOutput("frz_l0_held", {15'd0, evtREQ}, 16'd1);
      ackEvent("frz_l0_ack_drop");
      watchCycles(300);
      checkOutput("frz_noreq", {15'd0, sawReq}, 16'd0);
      checkOutput("frz_sts",   stsMSR, 16'h0081);
      applyStimulus(16'h1081, 1'b1);
      waitForReq(200);
      checkOutput("frz_l4_req",  {15'd0, evtREQ}, 16'd1);
      checkOutput("frz_l4_line", {13'd0, evtLINE}, 16'd4);
      checkOutput("frz_l4_co",   {15'd0, evtCO}, 16'd1);
      checkOutput("frz_l4_ri",   {15'd0, evtRI}, 16'd0);
      checkOutput("frz_l4_sts",  stsMSR, 16'h1081);
      ackEvent("frz_l4_ack_drop");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
